// File: rtl/gba_pe_pkg.sv
// gba_pe_pkg
// Shared definitions for the GBA compositor layer-priority sequencer:
// entry field positions, layer indices, the backdrop pseudo-layer, the
// sequencer state encoding and a helper that formats a backdrop entry.
// No ports (package).
package gba_pe_pkg;

  localparam int NUM_LAYERS = 5;
  localparam int ENTRY_W    = 20;
  localparam int IDX_W      = 3;
  localparam int COLOUR_W   = 16;
  localparam int PRIO_MSB   = 19;
  localparam int PRIO_LSB   = 17;
  localparam int TRANSP_BIT = 16;

  // Scan order of the candidates; the backdrop index is one past the last layer
  localparam logic [IDX_W-1:0] LAYER_OBJ      = 3'd0;
  localparam logic [IDX_W-1:0] LAYER_BG0      = 3'd1;
  localparam logic [IDX_W-1:0] LAYER_BG1      = 3'd2;
  localparam logic [IDX_W-1:0] LAYER_BG2      = 3'd3;
  localparam logic [IDX_W-1:0] LAYER_BG3      = 3'd4;
  localparam logic [IDX_W-1:0] LAYER_BACKDROP = 3'd5;

  localparam logic [2:0] BACKDROP_PRIO = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [2:0]          prio;
    logic                transparent;
    logic [COLOUR_W-1:0] colour;
  } pe_entry_t;

  // Backdrop is reported as an opaque entry at the weakest priority
  function automatic pe_entry_t backdrop_entry(input logic [COLOUR_W-1:0] colour);
    pe_entry_t e;
    e.prio        = BACKDROP_PRIO;
    e.transparent = 1'b0;
    e.colour      = colour;
    return e;
  endfunction

endpackage

// File: rtl/pe_slot_compare.sv
// pe_slot_compare
// Combinational priority comparator for one result slot. Decides whether the
// candidate should displace the slot's current holder.
// Ports:
//   cand       - candidate entry
//   cand_valid - candidate is enabled by the window mask and opaque
//   best       - entry currently held in the slot
//   best_valid - slot currently holds a real layer
//   replace    - candidate wins the slot
module pe_slot_compare
  import gba_pe_pkg::*;
(
  input  logic [ENTRY_W-1:0] cand,
  input  logic               cand_valid,
  input  logic [ENTRY_W-1:0] best,
  input  logic               best_valid,
  output logic               replace
);

  // Strict less-than: on a tie the earlier-scanned layer keeps the slot,
  // which is what makes OBJ beat an equal BG and BG0 beat BG1, etc.
  always_comb begin
    replace = cand_valid &&
              (!best_valid || (cand[PRIO_MSB:PRIO_LSB] < best[PRIO_MSB:PRIO_LSB]));
  end

endmodule

// File: rtl/priority_sequencer.sv
// priority_sequencer
// Per-pixel layer-priority scheduler. Accepts one pixel's OBJ + BG0..BG3
// candidates with the window mask, walks them through a shared comparator one
// per cycle, and reports the best and second-best visible layers. An empty
// slot reports the backdrop colour at layer index 5.
// Ports:
//   clock, reset          - clock and synchronous active-high reset
//   in_valid / in_ready   - candidate-set handshake
//   obj_entry, bg_entry   - candidates ({prio[2:0], transparent, colour[15:0]})
//   mask                  - window enables, bit0..3 = BG0..BG3, bit4 = OBJ
//   backdrop              - backdrop colour captured with the set
//   out_valid / out_ready - result handshake
//   top_entry/top_layer, second_entry/second_layer - ranked results
module priority_sequencer
  import gba_pe_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ENTRY_W-1:0]            obj_entry,
  input  logic [3:0][ENTRY_W-1:0]       bg_entry,
  input  logic [NUM_LAYERS-1:0]         mask,
  input  logic [COLOUR_W-1:0]           backdrop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ENTRY_W-1:0]            top_entry,
  output logic [IDX_W-1:0]              top_layer,
  output logic [ENTRY_W-1:0]            second_entry,
  output logic [IDX_W-1:0]              second_layer
);

  seq_state_e state_q, state_d;

  logic [NUM_LAYERS-1:0][ENTRY_W-1:0] ent_q, ent_d;
  logic [NUM_LAYERS-1:0]              mask_q, mask_d;
  logic [COLOUR_W-1:0]                backdrop_q, backdrop_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;

  logic [ENTRY_W-1:0] top_q, top_d;
  logic [IDX_W-1:0]   top_layer_q, top_layer_d;
  logic               top_valid_q, top_valid_d;
  logic [ENTRY_W-1:0] sec_q, sec_d;
  logic [IDX_W-1:0]   sec_layer_q, sec_layer_d;
  logic               sec_valid_q, sec_valid_d;

  logic [ENTRY_W-1:0] cand;
  logic               cand_vis;
  logic               cand_valid;
  logic               replace_top;
  logic               replace_sec;
  logic [ENTRY_W-1:0] backdrop_fmt;

  // State register; reset abandons any scan in progress
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept a set in IDLE, step through all five layers, then hold
  // the result until the consumer takes it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_SCAN;
      ST_SCAN: if (idx_q == LAYER_BG3) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  // Candidate under evaluation this cycle. The mask bit order differs from the
  // scan order (OBJ sits on mask bit 4), so the mapping is spelled out here.
  always_comb begin
    cand     = '0;
    cand_vis = 1'b0;
    case (idx_q)
      LAYER_OBJ: begin cand = ent_q[0]; cand_vis = mask_q[4]; end
      LAYER_BG0: begin cand = ent_q[1]; cand_vis = mask_q[0]; end
      LAYER_BG1: begin cand = ent_q[2]; cand_vis = mask_q[1]; end
      LAYER_BG2: begin cand = ent_q[3]; cand_vis = mask_q[2]; end
      LAYER_BG3: begin cand = ent_q[4]; cand_vis = mask_q[3]; end
      default:   begin cand = '0;       cand_vis = 1'b0;      end
    endcase
    cand_valid = cand_vis && !cand[TRANSP_BIT];
  end

  pe_slot_compare u_cmp_top (
    .cand       (cand),
    .cand_valid (cand_valid),
    .best       (top_q),
    .best_valid (top_valid_q),
    .replace    (replace_top)
  );

  pe_slot_compare u_cmp_second (
    .cand       (cand),
    .cand_valid (cand_valid),
    .best       (sec_q),
    .best_valid (sec_valid_q),
    .replace    (replace_sec)
  );

  // Datapath next values. A new top pushes the old top down to second; a
  // candidate that loses to top can still claim the second slot.
  always_comb begin
    ent_d       = ent_q;
    mask_d      = mask_q;
    backdrop_d  = backdrop_q;
    idx_d       = idx_q;
    top_d       = top_q;
    top_layer_d = top_layer_q;
    top_valid_d = top_valid_q;
    sec_d       = sec_q;
    sec_layer_d = sec_layer_q;
    sec_valid_d = sec_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ent_d       = {bg_entry, obj_entry};
          mask_d      = mask;
          backdrop_d  = backdrop;
          idx_d       = '0;
          top_d       = '0;
          top_layer_d = '0;
          top_valid_d = 1'b0;
          sec_d       = '0;
          sec_layer_d = '0;
          sec_valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (replace_top) begin
          sec_d       = top_q;
          sec_layer_d = top_layer_q;
          sec_valid_d = top_valid_q;
          top_d       = cand;
          top_layer_d = idx_q;
          top_valid_d = 1'b1;
        end else if (replace_sec) begin
          sec_d       = cand;
          sec_layer_d = idx_q;
          sec_valid_d = 1'b1;
        end
        idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath registers, cleared on reset so a stale scan leaves no trace
  always_ff @(posedge clock) begin
    if (reset) begin
      ent_q       <= '0;
      mask_q      <= '0;
      backdrop_q  <= '0;
      idx_q       <= '0;
      top_q       <= '0;
      top_layer_q <= '0;
      top_valid_q <= 1'b0;
      sec_q       <= '0;
      sec_layer_q <= '0;
      sec_valid_q <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      mask_q      <= mask_d;
      backdrop_q  <= backdrop_d;
      idx_q       <= idx_d;
      top_q       <= top_d;
      top_layer_q <= top_layer_d;
      top_valid_q <= top_valid_d;
      sec_q       <= sec_d;
      sec_layer_q <= sec_layer_d;
      sec_valid_q <= sec_valid_d;
    end
  end

  // Result presentation: empty slots become the backdrop, and everything reads
  // zero while no result is being offered
  always_comb begin
    backdrop_fmt = backdrop_entry(backdrop_q);
    top_entry    = '0;
    top_layer    = '0;
    second_entry = '0;
    second_layer = '0;
    if (state_q == ST_DONE) begin
      top_entry    = top_valid_q ? top_q : backdrop_fmt;
      top_layer    = top_valid_q ? top_layer_q : LAYER_BACKDROP;
      second_entry = sec_valid_q ? sec_q : backdrop_fmt;
      second_layer = sec_valid_q ? sec_layer_q : LAYER_BACKDROP;
    end
  end

endmodule
